// File: rtl/simple_fifo_wr_arbiter.sv
// ============================================================================
// Module   : simple_fifo_wr_arbiter
// Function : Round-robin arbiter sharing one simple_fifo write port among N
//            producers, with occupancy tracking that includes its own
//            in-flight write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module simple_fifo_wr_arbiter #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int N     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] req_data,
    output logic [N-1:0]       ack,
    output logic               fifo_we,
    output logic [WIDTH-1:0]   fifo_din,
    input  logic               fifo_full,
    input  logic [WIDTH-1:0]   fifo_count,
    output logic [2:0]         grant_id,
    output logic               busy
);

    localparam int               c_PW      = $clog2(N);
    localparam logic [WIDTH:0]   c_DEPTH   = (WIDTH + 1)'(DEPTH);
    localparam logic [N-1:0]     c_ACK_LSB = N'(1);
    localparam logic [c_PW-1:0]  c_LAST_RST = c_PW'(N - 1);

    logic [c_PW-1:0]  r_last;
    logic [WIDTH:0]   w_sum;
    logic             w_room;
    logic [N-1:0]     w_elig;
    logic             w_found;
    logic [c_PW-1:0]  w_gnt;
    logic [WIDTH-1:0] w_word;

    // The in-flight write is not yet visible in fifo_count, so count it here.
    assign w_sum  = {1'b0, fifo_count} + {{WIDTH{1'b0}}, fifo_we};
    assign w_room = !fifo_full && (w_sum < c_DEPTH);
    assign w_elig = req & ~ack;

    always_comb begin
        w_found = 1'b0;
        w_gnt   = r_last;
        for (int k = 1; k <= N; k++) begin
            if (!w_found && w_elig[c_PW'((int'(r_last) + k) % N)]) begin
                w_found = 1'b1;
                w_gnt   = c_PW'((int'(r_last) + k) % N);
            end
        end
    end

    always_comb begin
        w_word = '0;
        for (int i = 0; i < N; i++) begin
            if (c_PW'(i) == w_gnt) begin
                w_word = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_we  <= 1'b0;
            fifo_din <= '0;
            ack      <= '0;
            grant_id <= 3'd0;
            busy     <= 1'b0;
            r_last   <= c_LAST_RST;
        end else begin
            busy <= (|req) && !w_room;
            if (w_found && w_room) begin
                fifo_we  <= 1'b1;
                fifo_din <= w_word;
                ack      <= c_ACK_LSB << w_gnt;
                grant_id <= 3'(w_gnt);
                r_last   <= w_gnt;
            end else begin
                fifo_we  <= 1'b0;
                ack      <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_simple_fifo_wr_arbiter.sv
// ============================================================================
// Module   : tb_simple_fifo_wr_arbiter
// Function : Self-checking bench for simple_fifo_wr_arbiter with a FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simple_fifo_wr_arbiter;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int N     = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       ack;
    logic               fifo_we;
    logic [WIDTH-1:0]   fifo_din;
    logic               fifo_full;
    logic [WIDTH-1:0]   fifo_count;
    logic [2:0]         grant_id;
    logic               busy;
    logic               rd;

    int checks = 0;
    int errors = 0;
    bit model_chk = 1'b0;

    simple_fifo_wr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .fifo_we    (fifo_we),
        .fifo_din   (fifo_din),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Environment FIFO: count and full flag change one cycle after a write.
    logic [WIDTH-1:0] q[$];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            fifo_count <= '0;
            fifo_full  <= 1'b0;
        end else begin
            if (rd && q.size() > 0) void'(q.pop_front());
            if (fifo_we && q.size() < DEPTH) q.push_back(fifo_din);
            fifo_count <= WIDTH'(q.size());
            fifo_full  <= (q.size() == DEPTH);
        end
    end

    // Reference model: rotate from the last winner, skip just-acked requesters.
    function automatic int pick(logic [N-1:0] r, logic [N-1:0] a, int last);
        for (int off = 1; off <= N; off++) begin
            int i;
            i = (last + off) % N;
            if (r[i] && !a[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] word_of(logic [N*WIDTH-1:0] d, int i);
        return d[i*WIDTH +: WIDTH];
    endfunction

    logic [N-1:0]     m_ack;
    logic             m_we;
    logic [WIDTH-1:0] m_din;
    logic [2:0]       m_gid;
    logic             m_busy;
    int               m_last;
    int               m_w;
    logic             m_room;

    always_comb begin
        m_w    = pick(req, m_ack, m_last);
        m_room = !fifo_full && ((int'(fifo_count) + int'(m_we)) < DEPTH);
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ack  <= '0;
            m_we   <= 1'b0;
            m_din  <= '0;
            m_gid  <= 3'd0;
            m_busy <= 1'b0;
            m_last <= N - 1;
        end else begin
            m_busy <= (req != '0) && !m_room;
            if (m_w >= 0 && m_room) begin
                m_we   <= 1'b1;
                m_ack  <= N'(1) << m_w;
                m_din  <= word_of(req_data, m_w);
                m_gid  <= 3'(m_w);
                m_last <= m_w;
            end else begin
                m_we   <= 1'b0;
                m_ack  <= '0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (model_chk) begin
            chk("rnd_ack",  64'(ack),      64'(m_ack));
            chk("rnd_we",   64'(fifo_we),  64'(m_we));
            chk("rnd_din",  64'(fifo_din), 64'(m_din));
            chk("rnd_gid",  64'(grant_id), 64'(m_gid));
            chk("rnd_busy", 64'(busy),     64'(m_busy));
        end
    endtask

    task automatic set_word(input int i, input logic [WIDTH-1:0] v);
        req_data[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    typedef struct packed {
        logic [3:0] req;
        logic       rd;
        logic [3:0] ack;
        logic       we;
        logic [2:0] gid;
        logic       busy;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [WIDTH-1:0] exp_din;
        logic [WIDTH-1:0] seen [$];
        logic [WIDTH-1:0] d2;
        int writes, viol, acks3;

        tbl[0]  = '{4'hF, 1'b1, 4'h1, 1'b1, 3'd0, 1'b0};
        tbl[1]  = '{4'hF, 1'b1, 4'h2, 1'b1, 3'd1, 1'b0};
        tbl[2]  = '{4'hF, 1'b1, 4'h4, 1'b1, 3'd2, 1'b0};
        tbl[3]  = '{4'hF, 1'b1, 4'h8, 1'b1, 3'd3, 1'b0};
        tbl[4]  = '{4'hF, 1'b1, 4'h1, 1'b1, 3'd0, 1'b0};
        tbl[5]  = '{4'hF, 1'b1, 4'h2, 1'b1, 3'd1, 1'b0};
        tbl[6]  = '{4'h4, 1'b1, 4'h4, 1'b1, 3'd2, 1'b0};
        tbl[7]  = '{4'h4, 1'b1, 4'h0, 1'b0, 3'd2, 1'b0};
        tbl[8]  = '{4'h4, 1'b1, 4'h4, 1'b1, 3'd2, 1'b0};
        tbl[9]  = '{4'h4, 1'b1, 4'h0, 1'b0, 3'd2, 1'b0};
        tbl[10] = '{4'h0, 1'b1, 4'h0, 1'b0, 3'd2, 1'b0};

        reset    = 1'b0;
        req      = '0;
        req_data = '0;
        rd       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack",  64'(ack),      64'(0));
        chk("rst_we",   64'(fifo_we),  64'(0));
        chk("rst_din",  64'(fifo_din), 64'(0));
        chk("rst_gid",  64'(grant_id), 64'(0));
        chk("rst_busy", 64'(busy),     64'(0));
        reset = 1'b1;

        // Fairness and single-requester pacing, table driven.
        for (int i = 0; i < N; i++) set_word(i, 16'hA0A0 + 16'(i));
        exp_din = '0;
        for (int r = 0; r < 11; r++) begin
            req = tbl[r].req;
            rd  = tbl[r].rd;
            step();
            if (tbl[r].we) exp_din = 16'hA0A0 + 16'(tbl[r].gid);
            chk("tbl_ack",  64'(ack),      64'(tbl[r].ack));
            chk("tbl_we",   64'(fifo_we),  64'(tbl[r].we));
            chk("tbl_gid",  64'(grant_id), 64'(tbl[r].gid));
            chk("tbl_busy", 64'(busy),     64'(tbl[r].busy));
            chk("tbl_din",  64'(fifo_din), 64'(exp_din));
        end

        // Single requester with incrementing data: every other cycle, no duplicates.
        d2 = '0;
        set_word(2, d2);
        req = 4'b0100;
        for (int c = 0; c < 12; c++) begin
            step();
            chk("single_ack", 64'(ack), (c % 2 == 0) ? 64'h4 : 64'h0);
            if (fifo_we) seen.push_back(fifo_din);
            if (ack[2]) begin
                d2 = d2 + 16'd1;
                set_word(2, d2);
            end
        end
        chk("single_nwords", 64'(seen.size()), 64'(6));
        foreach (seen[j]) chk("single_word", 64'(seen[j]), 64'(j));

        // Asynchronous reset in the middle of a write.
        req = 4'b1111;
        step();
        chk("pre_rst_we", 64'(fifo_we), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        chk("arst_ack",  64'(ack),      64'(0));
        chk("arst_we",   64'(fifo_we),  64'(0));
        chk("arst_din",  64'(fifo_din), 64'(0));
        chk("arst_gid",  64'(grant_id), 64'(0));
        chk("arst_busy", 64'(busy),     64'(0));
        set_word(0, 16'h5A5A);
        req = 4'b0001;
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        chk("rel_ack", 64'(ack),      64'(1));
        chk("rel_we",  64'(fifo_we),  64'(1));
        chk("rel_din", 64'(fifo_din), 64'h5A5A);

        // Fill with no reads, then release exactly one slot.
        req = '0;
        rd  = 1'b0;
        reset_pulse();
        req = 4'b0011;
        writes = 0;
        viol   = 0;
        repeat (20) begin
            step();
            if (fifo_we) writes++;
            if (fifo_we && fifo_full) viol++;
        end
        chk("fill_writes", 64'(writes), 64'(8));
        chk("fill_busy",   64'(busy),   64'(1));
        chk("fill_full",   64'(fifo_full), 64'(1));
        writes = 0;
        rd = 1'b1;
        step();
        if (fifo_we) writes++;
        rd = 1'b0;
        repeat (10) begin
            step();
            if (fifo_we) writes++;
            if (fifo_we && fifo_full) viol++;
        end
        chk("pop_writes", 64'(writes), 64'(1));
        chk("pop_busy",   64'(busy),   64'(1));
        chk("full_viol",  64'(viol),   64'(0));

        // Withdraw from requester 3 while full, then requester 1 wins after wrap.
        req = '0;
        reset_pulse();
        req = 4'b1000;
        repeat (20) begin
            step();
            if (ack[3]) set_word(3, 16'($urandom));
        end
        chk("wd_full", 64'(fifo_full), 64'(1));
        chk("wd_gid",  64'(grant_id),  64'(3));
        acks3 = 0;
        repeat (3) begin
            step();
            if (ack[3]) acks3++;
        end
        req = 4'b0000;
        repeat (2) begin
            step();
            if (ack[3]) acks3++;
        end
        rd = 1'b1;
        step();
        if (ack[3]) acks3++;
        rd = 1'b0;
        chk("wd_no_ack3", 64'(acks3), 64'(0));
        set_word(1, 16'h1111);
        req = 4'b0010;
        step();
        chk("wrap_ack", 64'(ack),      64'(2));
        chk("wrap_gid", 64'(grant_id), 64'(1));
        chk("wrap_din", 64'(fifo_din), 64'h1111);

        // Randomized traffic against the reference model.
        req = '0;
        reset_pulse();
        model_chk = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                    set_word(i, 16'($urandom));
                end else if (req[i]) begin
                    if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    set_word(i, 16'($urandom));
                end
            end
            rd = ($urandom_range(0, 99) < ((n < 1500) ? 30 : 80));
            step();
        end
        model_chk = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/simple_fifo_wr_arbiter.md
# simple_fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of a `simple_fifo` instance (WIDTH=16, DEPTH=8 by default) among N independent producers. It registers one winning word per cycle onto the FIFO `we`/`din` pins and returns a one-cycle `ack` to the winner. It tracks FIFO occupancy, including its own in-flight write, so no write is ever issued into a full FIFO. It sits between the producer-side logic and the FIFO; the read side of the FIFO is untouched.

## Interface
- WIDTH, 16, data word width; also the width of the FIFO `count` input.
- DEPTH, 8, FIFO capacity in words; must match the attached FIFO.
- N, 4, number of requesters, 2..8.

- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N  per-requester write request; level, held until acked.
- req_data  in  N*WIDTH  requester i's word on bits [i*WIDTH +: WIDTH].
- ack  out  N  one-hot, one-cycle pulse: the requester's word is being written this cycle.
- fifo_we  out  1  FIFO write enable, registered.
- fifo_din  out  WIDTH  FIFO write data, registered.
- fifo_full  in  1  FIFO full flag.
- fifo_count  in  WIDTH  FIFO occupancy, updated one cycle after a sampled write.
- grant_id  out  3  index of the last granted requester; informational.
- busy  out  1  high when any `req` is pending but no grant is possible (FIFO has no room).

## Operation
- **Room check (combinational):** `room = !fifo_full && (fifo_count + fifo_we) < DEPTH`.
  - Sum is computed at WIDTH+1 bits, so it cannot wrap.
  - `fifo_we` accounts for the write currently in flight.
- **Eligible set:** `elig = req & ~ack`.
  - A requester whose `ack` is high this cycle is masked, so its just-written word is never written twice.
  - One requester can therefore win at most every other cycle.
  - Other requesters can fill the gap, so back-to-back FIFO writes are possible.
- **Round-robin pointer `last` (state, log2 N bits):**
  - Search starts at `last+1` and wraps modulo N.
  - The first eligible index wins.
  - `last` updates only on a grant.
- **On a grant to index g at rising edge:**
  - `fifo_we` ← 1
  - `fifo_din` ← word g
  - `ack` ← one-hot(g)
  - `grant_id` ← g
  - `last` ← g
- **No grant** (elig = 0 or !room): `fifo_we` ← 0, `ack` ← 0; `fifo_din`, `grant_id` and `last` hold.
- **`busy`** is registered: `busy` ← `(req != 0) && !room`.
- **Producer rule:** hold `req` and `req_data` stable until `ack` is sampled high. Then either drop `req` or present the next word; re-asserting `req` on the same cycle is legal.
- **`req` withdrawn before ack:** permitted; the requester is simply not granted.

## Timing
- **Reset (asynchronous, reset=0):**
  - `fifo_we` = 0, `fifo_din` = 0, `ack` = 0, `grant_id` = 0, `busy` = 0.
  - `last` = N-1, so requester 0 has first priority.
  - A reset mid-transfer discards the in-flight write.
  - Release is synchronous to clk via the normal flop path; the first grant is possible on the first edge after release.
- **Latency:** `req` high and sampled at edge k with room gives `fifo_we`/`ack` high during cycle k→k+1. The FIFO captures the word at edge k+1.
- **Throughput:** one word per cycle aggregate, when ≥2 requesters are active and the FIFO drains.
- **Full boundary:** at `fifo_count` = DEPTH-1 with `fifo_we` = 1, room = 0, so no grant that cycle. The next grant comes only after the count drops.
- **Simultaneous read and write at full:** the arbiter does not speculate on reads. It waits until `fifo_count` reflects the read.

## Test plan
- **Reset:** assert reset=0 mid-write (`fifo_we`=1) → all outputs 0 immediately; after release with req=4'b0001, ack=0001 one cycle later and `fifo_din` = req_data[15:0].
- **Single requester:**
  - Setup: req=4'b0100 held continuously, data increments on each ack.
  - Expected: `ack[2]` pulses every other cycle; the FIFO receives 0,1,2,… with no duplicates.
- **Fairness:**
  - Setup: req=4'b1111 held, empty FIFO drained every cycle.
  - Expected: grant order 0,1,2,3,0,…; `fifo_we` high every cycle after the first.
- **Fill:**
  - Setup: no reads; req=4'b0011.
  - Expected: exactly 8 writes total; `fifo_we` never high while `fifo_full`=1; `busy`=1 afterwards.
  - Then pop one word: exactly one more write occurs.
- **Withdraw and wrap:**
  - Setup: `last`=3, req=4'b1000 at a cycle with no room, then req=4'b0000.
  - Expected: no ack ever for requester 3; the next request from requester 1 is granted first.
